// File: rtl/db_to_signed_binary_12bit.sv
// Converts a whole-dB attenuation plus sign into a signed 12-bit linear sample.
// Uses 24 quarter-dB per octave: octave count sets a right shift, remainder indexes a mantissa table.
module db_to_signed_binary_12bit #(
  parameter int STEP_QDB = 24,
  parameter int MAX_OCT  = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  input_db,
  input  logic        input_negative,
  output logic [11:0] output_binary,
  output logic        done,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OCTAVE   = 3'd1,
    MANTISSA = 3'd2,
    SHIFT    = 3'd3,
    OUTPUT   = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [10:0] q;
  logic [3:0]  oct;
  logic        neg;
  logic [11:0] mag;

  // Handshake: start is sampled only while busy is low; done pulses once per
  // accepted request, in the first IDLE cycle, and output_binary holds its value
  // until the next done.

  // round(2047 * 10^(-r/80)), one entry per quarter-dB within an octave
  function automatic logic [11:0] mant_lookup(input logic [4:0] r);
    logic [11:0] v;
    case (r)
      5'd0:    v = 12'd2047;
      5'd1:    v = 12'd1989;
      5'd2:    v = 12'd1932;
      5'd3:    v = 12'd1878;
      5'd4:    v = 12'd1824;
      5'd5:    v = 12'd1773;
      5'd6:    v = 12'd1722;
      5'd7:    v = 12'd1673;
      5'd8:    v = 12'd1626;
      5'd9:    v = 12'd1580;
      5'd10:   v = 12'd1535;
      5'd11:   v = 12'd1491;
      5'd12:   v = 12'd1449;
      5'd13:   v = 12'd1408;
      5'd14:   v = 12'd1368;
      5'd15:   v = 12'd1329;
      5'd16:   v = 12'd1292;
      5'd17:   v = 12'd1255;
      5'd18:   v = 12'd1219;
      5'd19:   v = 12'd1185;
      5'd20:   v = 12'd1151;
      5'd21:   v = 12'd1118;
      5'd22:   v = 12'd1087;
      5'd23:   v = 12'd1056;
      default: v = 12'd0;
    endcase
    return v;
  endfunction

  logic can_sub;
  assign can_sub = (q >= 11'(STEP_QDB)) && (oct < 4'(MAX_OCT));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = OCTAVE;
      OCTAVE:   if (!can_sub) state_next = MANTISSA;
      MANTISSA: state_next = SHIFT;
      SHIFT:    if (oct == 4'd0) state_next = OUTPUT;
      OUTPUT:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q             <= '0;
      oct           <= '0;
      neg           <= 1'b0;
      mag           <= '0;
      output_binary <= '0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q   <= {input_db, 2'b00};
            neg <= input_negative;
            oct <= '0;
          end
        end
        OCTAVE: begin
          if (can_sub) begin
            q   <= q - 11'(STEP_QDB);
            oct <= oct + 4'd1;
          end
        end
        MANTISSA: begin
          mag <= (oct == 4'(MAX_OCT)) ? 12'd0 : mant_lookup(q[4:0]);
        end
        SHIFT: begin
          if (oct != 4'd0) begin
            mag <= mag >> 1;
            oct <= oct - 4'd1;
          end
        end
        OUTPUT: begin
          // mag never exceeds 2047, so negation cannot overflow; -0 stays 0
          output_binary <= neg ? (12'd0 - mag) : mag;
          done          <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
